mem_port_arbiter: RTL and testbench

- Shares one single-port instruction/data RAM between two requesters in the pipelined core: the fetch stage (IF) and the memory stage (M, loads and stores).
- Sequences each RAM access through a small FSM with a fixed read latency.
- Returns read data with a one-cycle valid pulse.
- Produces stall requests consumed by the hazard unit.
- Sits between the pipeline stage registers and the RAM model.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port RAM between the fetch stage (IF) and the memory stage
// (M). Each access is granted from IDLE and then sequenced with a fixed read
// latency. Read data comes back with a one-cycle valid pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ifReq/ifAddr        fetch request (held until ifValid) and address
//   ifData/ifValid      registered fetch data and its one-cycle valid pulse
//   mReq/mWe/mAddr/mWData  data request (held until mValid), store flag, address, store data
//   mRData/mValid       registered load data and its one-cycle completion pulse
//   ramEn/ramWe/ramAddr/ramWData  registered RAM command, one ramEn cycle per access
//   ramRData            RAM read data, valid MEM_LAT cycles after the ramEn cycle
//   stallF/stallM       combinational stall requests for the hazard unit
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifData,
    output logic              ifValid,
    input  logic              mReq,
    input  logic              mWe,
    input  logic [ADDR_W-1:0] mAddr,
    input  logic [DATA_W-1:0] mWData,
    output logic [DATA_W-1:0] mRData,
    output logic              mValid,
    output logic              ramEn,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWData,
    input  logic [DATA_W-1:0] ramRData,
    output logic              stallF,
    output logic              stallM
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [2:0]    LAT_LIM    = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_M, WR_M} state_t;

    state_t        state, state_nxt;
    logic [2:0]    lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          blocked;
    logic          grant_m;
    logic          grant_if;
    logic          rd_state;
    logic          rd_done;

    // A valid pulse marks the cycle in which the requester is still holding its
    // old request; granting then would start a duplicate access.
    assign blocked  = ifValid | mValid;
    assign grant_m  = (state == IDLE) && !blocked && mReq &&
                      !(ifReq && (starve_cnt == STARVE_LIM));
    assign grant_if = (state == IDLE) && !blocked && !grant_m && ifReq;
    assign rd_state = (state == RD_IF) || (state == RD_M);
    assign rd_done  = rd_state && (lat_cnt == LAT_LIM);

    assign stallF = ifReq & ~ifValid;
    assign stallM = mReq & ~mValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_m)       state_nxt = mWe ? WR_M : RD_M;
                else if (grant_if) state_nxt = RD_IF;
            end
            RD_IF, RD_M: if (rd_done) state_nxt = IDLE;
            WR_M:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // RAM command register: one ramEn cycle per grant, the cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramEn    <= 1'b0;
            ramWe    <= 1'b0;
            ramAddr  <= '0;
            ramWData <= '0;
        end else begin
            ramEn <= grant_m | grant_if;
            ramWe <= grant_m & mWe;
            if (grant_m)          ramAddr  <= mAddr;
            else if (grant_if)    ramAddr  <= ifAddr;
            if (grant_m && mWe)   ramWData <= mWData;
        end
    end

    // Latency counter is 0 in the ramEn cycle and reaches MEM_LAT in the cycle
    // the RAM presents read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  lat_cnt <= '0;
        else if (rd_state && !rd_done) lat_cnt <= lat_cnt + 3'd1;
        else                         lat_cnt <= '0;
    end

    // Capture and valid pulse share the same edge; data holds until next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifData  <= '0;
            mRData  <= '0;
            ifValid <= 1'b0;
            mValid  <= 1'b0;
        end else begin
            ifValid <= rd_done && (state == RD_IF);
            mValid  <= (rd_done && (state == RD_M)) || (state == WR_M);
            if (rd_done && (state == RD_IF)) ifData <= ramRData;
            if (rd_done && (state == RD_M))  mRData <= ramRData;
        end
    end

    // Counts M grants that overtook a pending fetch; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_m) begin
            if (!ifReq)                         starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM of fixed latency.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ifReq = 1'b0;
    logic [ADDR_W-1:0] ifAddr = '0;
    logic [DATA_W-1:0] ifData;
    logic              ifValid;
    logic              mReq = 1'b0;
    logic              mWe = 1'b0;
    logic [ADDR_W-1:0] mAddr = '0;
    logic [DATA_W-1:0] mWData = '0;
    logic [DATA_W-1:0] mRData;
    logic              mValid;
    logic              ramEn;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWData;
    logic [DATA_W-1:0] ramRData;
    logic              stallF;
    logic              stallM;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid),
        .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData),
        .mRData(mRData), .mValid(mValid),
        .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData),
        .ramRData(ramRData), .stallF(stallF), .stallM(stallM)
    );

    // Behavioural RAM: unwritten words return a fixed per-address pattern.
    logic [31:0] mem [0:255];
    bit   [255:0] written;
    logic [31:0] pipe [0:7];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h0050_0093;
            32'h104: return 32'h1234_5678;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        if (written[a[9:2]]) return mem[a[9:2]];
        return init_word(a);
    endfunction

    always @(posedge clk) begin
        if (ramEn && ramWe) begin
            mem[ramAddr[9:2]]     <= ramWData;
            written[ramAddr[9:2]] <= 1'b1;
        end
        pipe[0] <= (ramEn && !ramWe) ? read_word(ramAddr) : 32'h0;
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    assign ramRData = pipe[MEM_LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for either valid pulse; samples on negedges. The first
    // sampled negedge is the request cycle itself, so lat counts from it.
    task automatic wait_done(output bit got_m, output int lat, output bit saw_en,
                             output bit saw_we, output logic [31:0] en_addr,
                             output bit timeout);
        got_m = 0; lat = 0; saw_en = 0; saw_we = 0; en_addr = '0; timeout = 1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (ramEn) begin
                saw_en  = 1;
                saw_we  = ramWe;
                en_addr = ramAddr;
            end
            if (ifValid || mValid) begin
                got_m   = mValid;
                lat     = c;
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit          got_m, saw_en, saw_we, tmo;
    int          lat;
    logic [31:0] en_addr;
    int          en_cnt, v_cnt, v_at;
    logic [31:0] v_data;
    bit          exp_m [6];

    initial begin
        exp_m = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset then idle
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ifValid", ifValid, 0);
        check_eq("rst_mValid", mValid, 0);
        check_eq("rst_ramEn", ramEn, 0);
        check_eq("rst_ramWe", ramWe, 0);
        check_eq("rst_ramAddr", ramAddr, 0);
        check_eq("rst_ramWData", ramWData, 0);
        check_eq("rst_ifData", ifData, 0);
        check_eq("rst_mRData", mRData, 0);
        check_eq("rst_stalls", {stallF, stallM}, 0);
        tick();
        rst_n = 1'b1;
        en_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ramEn) en_cnt++;
        end
        check_eq("idle_ramEn_count", en_cnt, 0);

        // Single fetch
        tick();
        ifReq = 1'b1; ifAddr = 32'h40;
        #1 check_eq("fetch_stallF_req", stallF, 1);
        wait_done(got_m, lat, saw_en, saw_we, en_addr, tmo);
        check_eq("fetch_timeout", tmo, 0);
        check_eq("fetch_is_if", got_m, 0);
        check_eq("fetch_latency", lat, MEM_LAT + 2);
        check_eq("fetch_ramEn", saw_en, 1);
        check_eq("fetch_ramAddr", en_addr, 32'h40);
        check_eq("fetch_ramWe", saw_we, 0);
        check_eq("fetch_ifData", ifData, 32'h0050_0093);
        check_eq("fetch_stallF_done", stallF, 0);
        tick();
        ifReq = 1'b0;
        @(negedge clk);
        check_eq("fetch_single_pulse", ifValid, 0);
        check_eq("fetch_data_hold", ifData, 32'h0050_0093);

        // Store then load
        tick();
        mReq = 1'b1; mWe = 1'b1; mAddr = 32'h100; mWData = 32'hDEAD_BEEF;
        wait_done(got_m, lat, saw_en, saw_we, en_addr, tmo);
        check_eq("store_timeout", tmo, 0);
        check_eq("store_is_m", got_m, 1);
        check_eq("store_latency", lat, 2);
        check_eq("store_ramWe", saw_we, 1);
        check_eq("store_ramAddr", en_addr, 32'h100);
        check_eq("store_ramWData", ramWData, 32'hDEAD_BEEF);
        tick();
        mWe = 1'b0;
        wait_done(got_m, lat, saw_en, saw_we, en_addr, tmo);
        check_eq("load_timeout", tmo, 0);
        check_eq("load_is_m", got_m, 1);
        check_eq("load_latency", lat, MEM_LAT + 2);
        check_eq("load_ramWe", saw_we, 0);
        check_eq("load_mRData", mRData, 32'hDEAD_BEEF);
        tick();
        mReq = 1'b0;

        // Simultaneous requests: starvation guard lets IF in after 3 M grants
        tick();
        ifReq = 1'b1; ifAddr = 32'h40;
        mReq = 1'b1; mWe = 1'b0; mAddr = 32'h100;
        for (int a = 0; a < 6; a++) begin
            wait_done(got_m, lat, saw_en, saw_we, en_addr, tmo);
            check_eq($sformatf("arb%0d_timeout", a), tmo, 0);
            check_eq($sformatf("arb%0d_grant_m", a), got_m, exp_m[a]);
            check_eq($sformatf("arb%0d_addr", a), en_addr, exp_m[a] ? 32'h100 : 32'h40);
            check_eq($sformatf("arb%0d_latency", a), lat, MEM_LAT + 2);
            tick();
        end
        ifReq = 1'b0; mReq = 1'b0;

        // Reset mid-read
        tick();
        mReq = 1'b1; mWe = 1'b0; mAddr = 32'h104;
        tick();
        @(negedge clk);
        check_eq("rstmid_ramEn", ramEn, 1);
        tick();
        rst_n = 1'b0; mReq = 1'b0;
        #1;
        check_eq("rstmid_ramEn_clr", ramEn, 0);
        check_eq("rstmid_ramAddr_clr", ramAddr, 0);
        check_eq("rstmid_mRData_clr", mRData, 0);
        check_eq("rstmid_ifData_clr", ifData, 0);
        tick();
        tick();
        rst_n = 1'b1;
        v_cnt = 0; en_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mValid) v_cnt++;
            if (ramEn) en_cnt++;
        end
        check_eq("rstmid_no_mValid", v_cnt, 0);
        check_eq("rstmid_no_ramEn", en_cnt, 0);

        // Request dropped during RD_M
        tick();
        mReq = 1'b1; mWe = 1'b0; mAddr = 32'h104;
        tick();
        tick();
        mReq = 1'b0;
        v_cnt = 0; v_at = -1; v_data = '0;
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            if (mValid) begin
                v_cnt++;
                v_at = c;
                v_data = mRData;
            end
            if (c < 9) tick();
        end
        check_eq("drop_pulse_count", v_cnt, 1);
        check_eq("drop_pulse_cycle", v_at, MEM_LAT + 2);
        check_eq("drop_mRData", v_data, 32'h1234_5678);
        check_eq("drop_data_hold", mRData, 32'h1234_5678);
        check_eq("drop_stallM", stallM, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
